// File: rtl/ysyx_22041207_rd_arbiter.sv
// ysyx_22041207_rd_arbiter: shares one AXI read port between IF and MEM.
// One transaction at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req_*  / mem_req_*       request handshakes (valid/ready, addr, size)
//   if_resp_* / mem_resp_*      response handshakes (valid/ready, data)
//   rx_r_valid_i/rx_r_ready_o   read-address handshake towards AXI master
//   rx_r_addr_i/rx_r_size_i     read address and size
//   rx_data_valid/rx_data_ready read-data handshake, data on rx_data_read_o
//
// Optional feature
//   YSYX_22041207_ARB_RR_EN     round-robin grant on simultaneous requests;
//                               undefined: fixed priority, MEM over IF.

module ysyx_22041207_rd_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    input  logic [SW-1:0] if_req_size,
    output logic          if_resp_valid,
    input  logic          if_resp_ready,
    output logic [DW-1:0] if_resp_data,

    input  logic          mem_req_valid,
    output logic          mem_req_ready,
    input  logic [AW-1:0] mem_req_addr,
    input  logic [SW-1:0] mem_req_size,
    output logic          mem_resp_valid,
    input  logic          mem_resp_ready,
    output logic [DW-1:0] mem_resp_data,

    output logic          rx_r_valid_i,
    input  logic          rx_r_ready_o,
    output logic [AW-1:0] rx_r_addr_i,
    output logic [SW-1:0] rx_r_size_i,
    input  logic [DW-1:0] rx_data_read_o,
    input  logic          rx_data_valid,
    output logic          rx_data_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    state_e        state_q,  state_d;
    owner_e        owner_q,  owner_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [SW-1:0] size_q,   size_d;
    logic [DW-1:0] data_q,   data_d;
    logic          rvalid_q, rvalid_d;
    logic          dready_q, dready_d;
    logic          if_rv_q,  if_rv_d;
    logic          mem_rv_q, mem_rv_d;

    logic gnt_if;
    logic gnt_mem;
    logic req_fire;
    logic resp_fire;

`ifdef YSYX_22041207_ARB_RR_EN
    owner_e lg_q, lg_d;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        if (if_req_valid && mem_req_valid) begin
            gnt_mem = (lg_q == OWN_IF);
            gnt_if  = (lg_q == OWN_MEM);
        end else begin
            gnt_mem = mem_req_valid;
            gnt_if  = if_req_valid;
        end
    end
`else
    always_comb begin
        gnt_mem = mem_req_valid;
        gnt_if  = if_req_valid && !mem_req_valid;
    end
`endif

    // Readies are combinational; rst_n gates them so every output is
    // low while reset is held, even with a requester valid.
    assign if_req_ready  = rst_n && (state_q == ST_IDLE) && gnt_if;
    assign mem_req_ready = rst_n && (state_q == ST_IDLE) && gnt_mem;

    assign req_fire  = (if_req_valid && if_req_ready)
                     || (mem_req_valid && mem_req_ready);
    assign resp_fire = (if_rv_q && if_resp_ready)
                     || (mem_rv_q && mem_resp_ready);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        size_d   = size_q;
        data_d   = data_q;
        rvalid_d = rvalid_q;
        dready_d = dready_q;
        if_rv_d  = if_rv_q;
        mem_rv_d = mem_rv_q;
`ifdef YSYX_22041207_ARB_RR_EN
        lg_d     = lg_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    state_d  = ST_REQ;
                    rvalid_d = 1'b1;
                    if (gnt_mem) begin
                        owner_d = OWN_MEM;
                        addr_d  = mem_req_addr;
                        size_d  = mem_req_size;
                    end else begin
                        owner_d = OWN_IF;
                        addr_d  = if_req_addr;
                        size_d  = if_req_size;
                    end
`ifdef YSYX_22041207_ARB_RR_EN
                    lg_d = gnt_mem ? OWN_MEM : OWN_IF;
`endif
                end
            end
            ST_REQ: begin
                if (rx_r_ready_o) begin
                    state_d  = ST_WAIT;
                    rvalid_d = 1'b0;
                    dready_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rx_data_valid) begin
                    state_d  = ST_RESP;
                    data_d   = rx_data_read_o;
                    dready_d = 1'b0;
                    if (owner_q == OWN_MEM) begin
                        mem_rv_d = 1'b1;
                    end else begin
                        if_rv_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (resp_fire) begin
                    state_d  = ST_IDLE;
                    if_rv_d  = 1'b0;
                    mem_rv_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            size_q   <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
            dready_q <= 1'b0;
            if_rv_q  <= 1'b0;
            mem_rv_q <= 1'b0;
`ifdef YSYX_22041207_ARB_RR_EN
            lg_q     <= OWN_MEM;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            data_q   <= data_d;
            rvalid_q <= rvalid_d;
            dready_q <= dready_d;
            if_rv_q  <= if_rv_d;
            mem_rv_q <= mem_rv_d;
`ifdef YSYX_22041207_ARB_RR_EN
            lg_q     <= lg_d;
`endif
        end
    end

    assign rx_r_valid_i   = rvalid_q;
    assign rx_r_addr_i    = addr_q;
    assign rx_r_size_i    = size_q;
    assign rx_data_ready  = dready_q;
    assign if_resp_valid  = if_rv_q;
    assign mem_resp_valid = mem_rv_q;
    assign if_resp_data   = data_q;
    assign mem_resp_data  = data_q;

endmodule

// File: doc/ysyx_22041207_rd_arbiter.md
Name: ysyx_22041207_rd_arbiter

Overview:
- Shares the single AXI read port (rx_* handshake) between instruction fetch (IF) and data load (MEM).
- Accepts one request at a time, issues it on the rx read-address handshake, and captures the returned data in a buffer.
- Routes the buffered response back to the requester that owns it.
- Sits between the IF/MEM stages and the AXI read master, so the IF stage no longer drives the rx port directly.

Parameters:
- AW, 64, address width
- DW, 64, data width
- SW, 8, size field width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- if_req_valid  in  1  IF read request valid
- if_req_ready  out  1  IF request accepted when valid && ready
- if_req_addr  in  AW  IF read address
- if_req_size  in  SW  IF size code (IF drives 8'b00001111)
- if_resp_valid  out  1  IF response data available
- if_resp_ready  in  1  IF consumes response
- if_resp_data  out  DW  IF response data
- mem_req_valid / mem_req_ready / mem_req_addr / mem_req_size  same as IF, for MEM
- mem_resp_valid / mem_resp_ready / mem_resp_data  same as IF, for MEM
- rx_r_valid_i  out  1  read address valid to AXI master
- rx_r_ready_o  in  1  AXI master accepted address
- rx_r_addr_i  out  AW  read address
- rx_r_size_i  out  SW  read size
- rx_data_read_o  in  DW  read data
- rx_data_valid  in  1  read data valid
- rx_data_ready  out  1  arbiter accepts read data

Behaviour:
- State register: IDLE, REQ, WAIT, RESP. Also registered: owner (IF/MEM), addr_q, size_q, data_q.
- Reset: state=IDLE, owner=IF, addr_q/size_q/data_q=0. All outputs 0 immediately on rst_n low.
- Reset mid-transaction abandons the transaction; the AXI master shares rst_n.
- All handshakes complete on a rising edge with valid && ready both high.
- IDLE:
  - grant = MEM if mem_req_valid, else IF if if_req_valid (fixed priority).
  - <x>_req_ready = (state==IDLE) && grant==x. This is combinational from state and valids; only the granted requester sees ready.
  - On handshake: latch addr/size and owner, go to REQ.
  - A non-granted valid stays pending. Requesters hold addr/size stable while valid.
- REQ:
  - rx_r_valid_i=1, rx_r_addr_i=addr_q, rx_r_size_i=size_q, all held stable until rx_r_ready_o is sampled high.
  - Then go to WAIT.
- WAIT:
  - rx_data_ready=1.
  - On rx_data_valid: data_q <= rx_data_read_o, go to RESP.
- RESP:
  - <owner>_resp_valid=1, <owner>_resp_data=data_q. The other requester's resp_valid=0.
  - On <owner>_resp_ready: go to IDLE.
- Outside WAIT, rx_data_ready=0; rx_data_valid is ignored in IDLE/REQ/RESP (no capture, no response).
- Outside REQ, rx_r_valid_i=0 and rx_r_addr_i=addr_q.
- resp_data outputs show data_q when not valid.
- Minimum latency, with rx_r_ready_o and rx_data_valid high immediately:
  - request handshake at edge 0
  - rx_r_valid_i high in cycle 1
  - rx_data_ready high in cycle 2
  - resp_valid high in cycle 3
- Back-to-back throughput: one transaction per 4 cycles minimum.
- At most one outstanding transaction. No request is accepted until the previous response handshake completes.
- Address 0 is a legal request address.
- Responses return in acceptance order, and each goes only to its owner.

Optional Feature:
- Macro: YSYX_22041207_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Register last_grant (reset = MEM).
  - On simultaneous if_req_valid and mem_req_valid, grant the requester not in last_grant.
  - last_grant updates on each request handshake.
  - With a single requester valid, that requester is granted.
- Undefined: fixed priority, MEM over IF. No last_grant register exists.

Test Plan:
- IF-only request addr 0x80000000. rx_r_ready_o=1, rx_data_valid=1 with data 0x0010009300000013 -> rx_r_addr_i=0x80000000 in cycle 1; if_resp_valid in cycle 3 with that data; mem_resp_valid stays 0.
- Simultaneous IF 0x80000004 and MEM 0x80001000 ->
  - Fixed priority: rx_r_addr_i=0x80001000 first; IF is issued only after the mem_resp handshake; if_req_ready stays low meanwhile.
  - With RR_EN after reset: IF 0x80000004 is issued first.
- Backpressure: rx_r_ready_o low 5 cycles -> rx_r_valid_i=1 and addr stable all 5 cycles. Then mem_resp_ready low 4 cycles -> mem_resp_valid/data held stable; no new rx_r_valid_i.
- Spurious rx_data_valid in IDLE with data 0xDEAD -> rx_data_ready=0, no resp_valid, data_q unchanged.
- rst_n asserted while in WAIT -> all outputs 0 without waiting for a clock edge. After release, an IF request to 0x80000008 completes normally.
- Four back-to-back IF requests, 0x80000000..0x8000000C, with immediate downstream -> four in-order responses; each if_req_ready pulse only in IDLE; 4-cycle spacing.
